// File: rtl/sram_ctrl.sv
// sram_ctrl -- single-port SRAM array access sequencer.
//
// Sequences one read or write through precharge, word-line and (for reads)
// sense phases. The analog-facing pins are modelled as real-valued rails that
// sit at either VDD (1.5) or VSS (0.0).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req/we/addr/wdata  access request (captured when ready is high)
//   ready           controller idle, a request will be accepted
//   row_rd[ROWS]    word-line drive (real)
//   pre_en, sae     bit-line precharge / sense-amp enables (real)
//   wr_bl, wr_blb   differential write drivers per column (real)
//   preout[COLS]    sense-amp outputs (real, input)
//   rd_data         last completed read word
//   rd_valid, wr_done, err  one-cycle completion pulses
//   dbg_state       current FSM state for debug / assertion binding
//
// Handshake: an access is accepted on a rising edge where req && ready.
// While busy, ready is low and req is ignored entirely (nothing is queued);
// completion is signalled by a single-cycle rd_valid or wr_done pulse.
module sram_ctrl #(
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 2,
  localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [COLS-1:0] wdata,
  output logic            ready,
  output real             row_rd [0:ROWS-1],
  output real             pre_en,
  output real             sae,
  output real             wr_bl  [0:COLS-1],
  output real             wr_blb [0:COLS-1],
  input  real             preout [0:COLS-1],
  output logic [COLS-1:0] rd_data,
  output logic            rd_valid,
  output logic            wr_done,
  output logic            err,
  output logic [2:0]      dbg_state
);

  localparam real VDD      = 1.5;
  localparam real VSS      = 0.0;
  localparam real SENSE_TH = 0.8;

  // Counter holds "remaining cycles minus one" so a phase ends when it is zero.
  localparam logic [3:0]  PRE_LOAD = 4'(PRE_CYC - 1);
  localparam logic [3:0]  WL_LOAD  = 4'(WL_CYC - 1);
  localparam logic [AW:0] ROWS_LIM = (AW + 1)'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_WL    = 3'd2,
    S_SENSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] wdata_q, wdata_d;
  logic [COLS-1:0] rd_data_q, rd_data_d;
  logic [COLS-1:0] sensed;
  logic            addr_oor;
  logic            row_on;
  logic            wl_write;

  // Captured address beyond the populated rows: no word line, zero read data.
  assign addr_oor = ({1'b0, addr_q} >= ROWS_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Digital threshold of the sense-amp outputs.
  always_comb begin
    sensed = '0;
    for (int c = 0; c < COLS; c++) begin
      sensed[c] = (preout[c] >= SENSE_TH);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_PRE;
          cnt_d   = PRE_LOAD;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      S_PRE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_WL;
          cnt_d   = WL_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WL: begin
        if (cnt_q == 4'd0) begin
          state_d = we_q ? S_DONE : S_SENSE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SENSE: begin
        state_d   = S_DONE;
        rd_data_d = addr_oor ? '0 : sensed;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The word line stays up through SENSE so the cell keeps driving the bit lines.
  assign row_on   = (state_q == S_WL) || (state_q == S_SENSE);
  assign wl_write = (state_q == S_WL) && we_q;

  always_comb begin
    pre_en = (state_q == S_PRE) ? VDD : VSS;
    sae    = (state_q == S_SENSE) ? VDD : VSS;
    for (int r = 0; r < ROWS; r++) begin
      row_rd[r] = (row_on && (addr_q == AW'(r))) ? VDD : VSS;
    end
    for (int c = 0; c < COLS; c++) begin
      wr_bl[c]  = (wl_write && wdata_q[c])  ? VDD : VSS;
      wr_blb[c] = (wl_write && !wdata_q[c]) ? VDD : VSS;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign rd_valid  = (state_q == S_DONE) && !we_q;
  assign wr_done   = (state_q == S_DONE) && we_q;
  assign err       = (state_q == S_DONE) && addr_oor;
  assign rd_data   = rd_data_q;
  assign dbg_state = state_q;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ROWS, default 16, number of word rows in the array.
REQ-002 Parameter COLS, default 8, bits per word.
REQ-003 Parameter PRE_CYC, default 2, precharge duration in clocks, legal range 1..15.
REQ-004 Parameter WL_CYC, default 2, word-line-on duration in clocks, legal range 1..15.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  1  access request, qualified by ready.
REQ-008 we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 addr  input  $clog2(ROWS)  target row; sampled with req.
REQ-010 wdata  input  COLS  write data; sampled with req.
REQ-011 ready  output  1  controller idle, request can be accepted.
REQ-012 row_rd  output  real [0:ROWS-1]  word-line drive, VDD=1.5 or VSS=0.0.
REQ-013 pre_en  output  real  bit-line precharge enable, VDD/VSS.
REQ-014 sae  output  real  sense-amp enable, VDD/VSS.
REQ-015 wr_bl, wr_blb  output  real [0:COLS-1]  write drivers; VSS on both when not writing.
REQ-016 preout  input  real [0:COLS-1]  sense-amp outputs.
REQ-017 rd_data  output  COLS  latched read word.
REQ-018 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-019 wr_done  output  1  one-cycle pulse, write complete.
REQ-020 err  output  1  one-cycle pulse with rd_valid/wr_done when addr >= ROWS.

Function
REQ-021 FSM states IDLE, PRE, WL, SENSE, DONE; a 4-bit counter times PRE and WL.
REQ-022 IDLE: ready=1; on rising edge with req=1, capture we/addr/wdata, load counter, go to PRE.
REQ-023 All other states: ready=0; req is ignored and not queued.
REQ-024 PRE: pre_en=VDD for exactly PRE_CYC cycles, then go to WL; pre_en=VSS in every other state.
REQ-025 WL: row_rd[addr]=VDD, all other rows VSS, for exactly WL_CYC cycles; for addr >= ROWS no row is driven.
REQ-026 WL with we=1: wr_bl[c]=VDD/wr_blb[c]=VSS for wdata[c]=1 and the inverse for 0; after WL_CYC cycles go to DONE.
REQ-027 WL with we=0: write drivers at VSS; after WL_CYC cycles go to SENSE.
REQ-028 SENSE: one cycle; row_rd[addr] stays VDD, sae=VDD; at end of cycle rd_data[c] <= (preout[c] >= 0.8); go to DONE.
REQ-029 DONE: one cycle; rd_valid=1 for a read or wr_done=1 for a write; err=1 if addr >= ROWS; go to IDLE.
REQ-030 Read with addr >= ROWS: rd_data latched as all zeros.
REQ-031 rd_data holds its value until the next read completes; writes do not modify it.
REQ-032 Read latency: rd_valid is high in the cycle after edge PRE_CYC+WL_CYC+1 counted from the accept edge; write latency: wr_done after edge PRE_CYC+WL_CYC.
REQ-033 Back-to-back: req held high is re-accepted in the IDLE cycle following DONE; at most one access per PRE_CYC+WL_CYC+3 cycles.
REQ-034 pre_en, any row_rd, and sae are never simultaneously VDD; pre_en and row_rd never overlap.

Reset
REQ-035 rst=1 on a rising edge forces IDLE, counter=0, and all real outputs to VSS.
REQ-036 The same reset edge also forces rd_data=0 and rd_valid=wr_done=err=0; ready=1 in the cycle after reset.
REQ-037 Reset mid-access aborts the access with no completion pulse; rst has priority over req.

Verification
REQ-038 Write addr=5, wdata=8'hA5: pre_en high 2 cycles, then row_rd[5]=1.5 for 2 cycles with wr_bl=A5 pattern; wr_done after edge 4.
REQ-039 Read addr=5 with preout=A5 pattern (1.5/0.0): sae high 1 cycle, then rd_valid with rd_data=8'hA5 after edge 5.
REQ-040 req held high during a read: no second accept until IDLE; the second access starts 7 cycles after the first.
REQ-041 rst asserted during WL: next cycle all outputs VSS/0, ready=1, no rd_valid pulse.
REQ-042 preout=0.79 on all columns: rd_data=8'h00; preout=0.8: rd_data=8'hFF.
REQ-043 ROWS=12 build, read addr=13: no row driven, rd_valid=1, err=1, rd_data=0.
